// File: rtl/instr_decode_stage_if.sv
// Fetch-side and execute-side bus of the decode stage.
// The master modport is the environment (fetch plus downstream consumer).
// The slave modport is the decode stage itself.
interface instr_decode_stage_if #(
  parameter int PC_W = 32
);
  logic            Flush;
  logic            InValid;
  logic            InReady;
  logic [31:0]     InInstr;
  logic [PC_W-1:0] InPC;
  logic            OutValid;
  logic            OutReady;
  logic [PC_W-1:0] OutPC;
  logic [5:0]      Opcode;
  logic [4:0]      Rs;
  logic [4:0]      Rt;
  logic [4:0]      Rd;
  logic [4:0]      Shamt;
  logic [5:0]      Funct;
  logic [15:0]     Imm16;
  logic            ImmZeroExt;
  logic            IsImmType;

  modport master (
    output Flush, InValid, InInstr, InPC, OutReady,
    input  InReady, OutValid, OutPC, Opcode, Rs, Rt, Rd, Shamt, Funct,
           Imm16, ImmZeroExt, IsImmType
  );

  modport slave (
    input  Flush, InValid, InInstr, InPC, OutReady,
    output InReady, OutValid, OutPC, Opcode, Rs, Rt, Rd, Shamt, Funct,
           Imm16, ImmZeroExt, IsImmType
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Decode stage: a 2-entry skid FIFO of fetched instructions whose head entry
// is field-split into opcode, register indices, shamt, funct, the raw 16-bit
// immediate for the sign extender, and the immediate-class flags.
// Every output comes from registered storage, so fetch and execute share no
// combinational path.
module instr_decode_stage #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input logic                  Clk,
  input logic                  Rst_n,
  instr_decode_stage_if.slave  bus
);

  logic [31:0]     instrBuf_p0 [DEPTH];
  logic [PC_W-1:0] pcBuf_p0    [DEPTH];
  logic            wrPtr;
  logic            rdPtr;
  logic [1:0]      count;
  logic            push;
  logic            pop;
  logic [31:0]     headInstr;
  logic [5:0]      headOp;

  // Handshake qualifiers; ready depends only on the registered count.
  assign bus.InReady  = (count < 2'(DEPTH));
  assign bus.OutValid = (count != 2'd0);
  assign push = bus.InValid && bus.InReady;
  assign pop  = bus.OutValid && bus.OutReady;

  // Control state: pointers and occupancy; flush outranks push and pop.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else if (bus.Flush) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wrPtr <= ~wrPtr;
      if (pop)  rdPtr <= ~rdPtr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the idle outputs read as a zero word.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instrBuf_p0[i] <= '0;
        pcBuf_p0[i]    <= '0;
      end
    end else if (push && !bus.Flush) begin
      instrBuf_p0[wrPtr] <= bus.InInstr;
      pcBuf_p0[wrPtr]    <= bus.InPC;
    end
  end

  // ---- p0 -> p1: head entry split into decode fields ----
  assign headInstr = instrBuf_p0[rdPtr];
  assign headOp    = headInstr[31:26];

  assign bus.OutPC  = pcBuf_p0[rdPtr] + PC_W'(4);
  assign bus.Opcode = headOp;
  assign bus.Rs     = headInstr[25:21];
  assign bus.Rt     = headInstr[20:16];
  assign bus.Rd     = headInstr[15:11];
  assign bus.Shamt  = headInstr[10:6];
  assign bus.Funct  = headInstr[5:0];
  assign bus.Imm16  = headInstr[15:0];

  // ANDI/ORI/XORI zero-extend; everything except R-type, J and JAL carries an immediate.
  always_comb begin
    bus.ImmZeroExt = (headOp == 6'h0C) || (headOp == 6'h0D) || (headOp == 6'h0E);
    bus.IsImmType  = !((headOp == 6'h00) || (headOp == 6'h02) || (headOp == 6'h03));
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: the driver pushes the decoded
// expectation of every accepted word, the monitor checks the head each cycle.
module tb_instr_decode_stage;

  localparam int PC_W = 32;

  typedef struct packed {
    logic [31:0] pc4;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic        zx;
    logic        it;
  } exp_t;

  logic Clk;
  logic Rst_n;
  int   errors;
  int   checks;
  int   popCount;
  exp_t expQ[$];

  instr_decode_stage_if #(.PC_W(PC_W)) bus ();

  instr_decode_stage #(.PC_W(PC_W), .DEPTH(2)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference decode using plain arithmetic on the instruction value.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t m;
    int unsigned w;
    int unsigned op;
    w  = ins;
    op = w / 32'd67108864;
    m.op  = 6'(op);
    m.rs  = 5'((w / 32'd2097152) % 32);
    m.rt  = 5'((w / 32'd65536) % 32);
    m.rd  = 5'((w / 32'd2048) % 32);
    m.sh  = 5'((w / 32'd64) % 32);
    m.fn  = 6'(w % 64);
    m.imm = 16'(w % 65536);
    m.zx  = (op == 12) || (op == 13) || (op == 14);
    m.it  = !((op == 0) || (op == 2) || (op == 3));
    m.pc4 = pc + 32'd4;
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // Drive one cycle starting just after a rising edge; records acceptance in the model.
  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                       input logic rdy, input logic fl, output logic acc);
    bus.InInstr  = ins;
    bus.InPC     = pc;
    bus.InValid  = v;
    bus.OutReady = rdy;
    bus.Flush    = fl;
    @(negedge Clk);
    acc = v && bus.InReady && !fl;
    @(posedge Clk);
    if (fl) expQ.delete();
    else if (acc) expQ.push_back(model(ins, pc));
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    logic a;
    for (int i = 0; i < n; i++) drive(32'h0, 32'h0, 1'b0, rdy, 1'b0, a);
  endtask

  // Monitor: compare handshake state and head fields, then retire consumed heads.
  always @(negedge Clk) begin
    if (Rst_n) begin
      exp_t act;
      act = {bus.OutPC, bus.Opcode, bus.Rs, bus.Rt, bus.Rd, bus.Shamt, bus.Funct,
             bus.Imm16, bus.ImmZeroExt, bus.IsImmType};
      chk("InReady", 64'(bus.InReady), 64'(expQ.size() < 2));
      chk("OutValid", 64'(bus.OutValid), 64'(expQ.size() > 0));
      if (bus.OutValid && expQ.size() > 0) begin
        checks++;
        if (act !== expQ[0]) begin
          errors++;
          $display("FAIL head: got %h expected %h", act, expQ[0]);
        end
        if (bus.OutReady && !bus.Flush) begin
          void'(expQ.pop_front());
          popCount++;
        end
      end
    end
  end

  initial begin
    logic        a;
    logic [31:0] curI;
    logic [31:0] curP;
    logic        curV;
    logic        holding;
    int          p0;
    int          ops[7];
    ops = '{0, 2, 3, 8, 12, 13, 14};
    errors = 0;
    checks = 0;
    popCount = 0;
    Rst_n = 1'b0;
    bus.Flush = 1'b0;
    bus.InValid = 1'b0;
    bus.OutReady = 1'b0;
    bus.InInstr = '0;
    bus.InPC = '0;

    #2;
    chk("rst_OutValid", 64'(bus.OutValid), 64'd0);
    chk("rst_OutPC", 64'(bus.OutPC), 64'd4);
    chk("rst_Opcode", 64'(bus.Opcode), 64'd0);
    chk("rst_Imm16", 64'(bus.Imm16), 64'd0);
    chk("rst_IsImmType", 64'(bus.IsImmType), 64'd0);
    #10 Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("post_rst_InReady", 64'(bus.InReady), 64'd1);

    // Single ADDI-like push, visible the cycle after the accepting edge.
    drive(32'h2108FFFC, 32'h100, 1'b1, 1'b1, 1'b0, a);
    chk("addi_OutValid", 64'(bus.OutValid), 64'd1);
    chk("addi_Opcode", 64'(bus.Opcode), 64'h08);
    chk("addi_Rs", 64'(bus.Rs), 64'd8);
    chk("addi_Rt", 64'(bus.Rt), 64'd8);
    chk("addi_Imm16", 64'(bus.Imm16), 64'hFFFC);
    chk("addi_ImmZeroExt", 64'(bus.ImmZeroExt), 64'd0);
    chk("addi_IsImmType", 64'(bus.IsImmType), 64'd1);
    chk("addi_OutPC", 64'(bus.OutPC), 64'h104);
    idle(1'b1, 1);
    chk("addi_popped", 64'(bus.OutValid), 64'd0);

    drive(32'h342100FF, 32'h200, 1'b1, 1'b1, 1'b0, a);
    chk("ori_Opcode", 64'(bus.Opcode), 64'h0D);
    chk("ori_Imm16", 64'(bus.Imm16), 64'h00FF);
    chk("ori_ImmZeroExt", 64'(bus.ImmZeroExt), 64'd1);
    chk("ori_IsImmType", 64'(bus.IsImmType), 64'd1);
    idle(1'b1, 1);

    drive(32'h012A4020, 32'h300, 1'b1, 1'b1, 1'b0, a);
    chk("rtype_fields", 64'({bus.Opcode, bus.Rs, bus.Rt, bus.Rd, bus.Shamt, bus.Funct}),
        64'({6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20}));
    chk("rtype_flags", 64'({bus.IsImmType, bus.ImmZeroExt}), 64'd0);
    idle(1'b1, 1);

    // Backpressure: A and B fill the FIFO, C waits, then all drain in order.
    drive(32'hAAAA0001, 32'h400, 1'b1, 1'b0, 1'b0, a);
    drive(32'hBBBB0002, 32'h404, 1'b1, 1'b0, 1'b0, a);
    chk("full_InReady", 64'(bus.InReady), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(32'h3CCC0003, 32'h408, 1'b1, 1'b0, 1'b0, a);
      chk("full_no_accept", 64'(a), 64'd0);
    end
    p0 = popCount;
    a = 1'b0;
    for (int i = 0; i < 5 && !a; i++) drive(32'h3CCC0003, 32'h408, 1'b1, 1'b1, 1'b0, a);
    chk("held_word_accepted", 64'(a), 64'd1);
    idle(1'b1, 4);
    chk("drain_pops", 64'(popCount - p0), 64'd3);
    chk("drain_empty", 64'(bus.OutValid), 64'd0);

    // Flush with a full FIFO and a coincident word that must vanish.
    drive(32'h11110001, 32'h500, 1'b1, 1'b0, 1'b0, a);
    drive(32'h22220002, 32'h504, 1'b1, 1'b0, 1'b0, a);
    drive(32'hDEAD0003, 32'h508, 1'b1, 1'b1, 1'b1, a);
    chk("flush_OutValid", 64'(bus.OutValid), 64'd0);
    chk("flush_InReady", 64'(bus.InReady), 64'd1);
    idle(1'b1, 3);

    // Asynchronous reset with one entry buffered.
    drive(32'h2108FFFC, 32'h600, 1'b1, 1'b0, 1'b0, a);
    bus.InValid = 1'b0;
    #1 Rst_n = 1'b0;
    #1;
    chk("arst_OutValid", 64'(bus.OutValid), 64'd0);
    chk("arst_OutPC", 64'(bus.OutPC), 64'd4);
    chk("arst_Opcode", 64'(bus.Opcode), 64'd0);
    expQ.delete();
    #1 Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Streaming: one instruction in and one out every cycle.
    p0 = popCount;
    for (int i = 0; i < 20; i++) begin
      drive($urandom, 32'h700 + 32'(i * 4), 1'b1, 1'b1, 1'b0, a);
      chk("stream_accept", 64'(a), 64'd1);
    end
    chk("stream_pops", 64'(popCount - p0), 64'd19);
    idle(1'b1, 3);

    // Random traffic with flushes; a refused word is held until accepted.
    holding = 1'b0;
    curI = '0;
    curP = '0;
    curV = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic fl;
      fl = ($urandom_range(0, 39) == 0);
      if (!holding) begin
        curI = $urandom;
        if ($urandom_range(0, 1) == 1) curI[31:26] = 6'(ops[$urandom_range(0, 6)]);
        curP = $urandom;
        curV = ($urandom_range(0, 3) != 0);
      end
      drive(curI, curP, curV, ($urandom_range(0, 2) != 0), fl, a);
      holding = curV && !a && !fl;
    end
    idle(1'b1, 4);
    chk("final_empty", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Decode stage that sits directly upstream of the immediate sign extender in the hash processor datapath.
- Accepts fetched 32-bit instructions and their PC over a valid/ready handshake, and buffers them in a 2-entry skid FIFO.
- Presents registered, field-split outputs: opcode, register indices, shamt, funct, the raw 16-bit immediate that drives the sign extender's DataIn, and an extension-select flag.
- Breaks the combinational path between fetch and execute.

Parameters:
- PC_W, 32, width of the program counter carried with each instruction
- DEPTH, 2, FIFO entries (fixed at 2; other values unsupported)

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Flush  input  1  synchronous: discard all buffered instructions
- InValid  input  1  fetch presents an instruction
- InReady  output  1  stage can accept
- InInstr  input  32  instruction word
- InPC  input  PC_W  PC of instruction
- OutValid  output  1  head entry valid
- OutReady  input  1  downstream consumes head
- OutPC  output  PC_W  PC of head, plus 4 (modulo 2^PC_W)
- Opcode  output  6  instr[31:26]
- Rs  output  5  instr[25:21]
- Rt  output  5  instr[20:16]
- Rd  output  5  instr[15:11]
- Shamt  output  5  instr[10:6]
- Funct  output  6  instr[5:0]
- Imm16  output  16  instr[15:0], feeds sign extender DataIn
- ImmZeroExt  output  1  1 when opcode is 0x0C, 0x0D or 0x0E (ANDI/ORI/XORI)
- IsImmType  output  1  1 when opcode is not 0x00, 0x02 or 0x03

Behaviour:
- Reset (Rst_n=0, async):
  - count=0, read/write pointers=0, all storage=0.
  - OutValid=0; all field outputs=0; OutPC=4.
  - InReady=1 once reset deasserts.
- Handshakes:
  - Push when InValid&&InReady at rising Clk.
  - Pop when OutValid&&OutReady at rising Clk.
  - InReady = (count<2), derived from registered count only; no combinational path from OutReady.
  - OutValid = (count>0).
- Latency:
  - Instruction pushed at edge N appears on the outputs in the cycle after edge N, provided the FIFO was empty.
  - No same-cycle bypass.
- Output source:
  - All decode outputs are driven from the head entry (read pointer).
  - Field extraction is pure slicing of the stored word.
  - ImmZeroExt/IsImmType are combinational from the stored opcode, so they are registered in effect.
- Simultaneous events:
  - Push+pop with count=1: count stays 1; the new entry becomes head next cycle.
  - Push+pop with count=0: no pop, since OutValid=0.
  - count=2: InReady=0, so no push; a pop reduces count to 1.
- Pointers: 1-bit, wrap 1->0.
- Flush has priority over push and pop in the same cycle:
  - count<=0 and pointers<=0.
  - OutValid=0 next cycle.
  - A coincident InValid word is dropped.
- While OutValid=0, held outputs may retain stale data; downstream must qualify with OutValid.
- Input stability: the bench/fetch holds InInstr/InPC stable while InValid&&!InReady. The stage does not check this.
- Reset mid-operation: all contents are lost immediately, asynchronously, and outputs go to their reset values.

Test Plan:
- Single push of 0x2108FFFC, PC=0x100, OutReady=1 -> next cycle:
  - OutValid=1, Opcode=0x08, Rs=8, Rt=8, Imm16=0xFFFC
  - ImmZeroExt=0, IsImmType=1, OutPC=0x104
  - OutValid drops after the pop.
- Push 0x342100FF (ORI) -> Opcode=0x0D, Imm16=0x00FF, ImmZeroExt=1, IsImmType=1.
- Push R-type 0x012A4020 -> Opcode=0, Rs=9, Rt=10, Rd=8, Shamt=0, Funct=0x20, IsImmType=0, ImmZeroExt=0.
- Backpressure:
  - OutReady=0; push A and B -> InReady=0 after the 2nd push.
  - Third word is held and not accepted.
  - Raise OutReady -> A, B, C emerge in order, with no loss or duplication.
- Flush with count=2 plus a concurrent InValid -> next cycle OutValid=0, InReady=1; the concurrent word never appears.
- Assert Rst_n=0 mid-stream with count=1 -> OutValid=0 and OutPC=4 without waiting for a clock edge.
- Streaming with InValid=OutReady=1 every cycle -> one instruction per cycle, throughput 1.
